// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: flow opcodes, FSM state encodings and default widths for pc_sequencer.
package pc_seq_pkg;

    localparam int PC_W_DEFAULT = 8;
    localparam int STACK_DEPTH_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        FETCH  = 3'd2,
        DECODE = 3'd3,
        EXEC   = 3'd4,
        HALT   = 3'd5
    } SeqState;

    localparam logic [2:0] FLOW_SEQ  = 3'd0;
    localparam logic [2:0] FLOW_BR   = 3'd1;
    localparam logic [2:0] FLOW_JMP  = 3'd2;
    localparam logic [2:0] FLOW_CALL = 3'd3;
    localparam logic [2:0] FLOW_RET  = 3'd4;
    localparam logic [2:0] FLOW_HALT = 3'd5;

endpackage

// File: rtl/ret_stack.sv
// ret_stack: LIFO of return addresses with full/empty status; top entry readable combinationally.
module ret_stack #(
    parameter int PC_W = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] pushData,
    output logic [PC_W-1:0] topData,
    output logic            full,
    output logic            empty
);
    localparam int AW = $clog2(STACK_DEPTH);
    localparam logic [AW:0] ONE = 1;

    logic [PC_W-1:0] mem [STACK_DEPTH];
    logic [AW:0] sp;
    logic [AW:0] spDec;

    assign spDec = sp - ONE;
    assign full = sp == (AW + 1)'(STACK_DEPTH);
    assign empty = sp == '0;
    assign topData = mem[spDec[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sp <= '0;
        else if (push && !full)
            sp <= sp + ONE;
        else if (pop && !empty)
            sp <= spDec;
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[sp[AW-1:0]] <= pushData;
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute FSM producing the registered pc.NextI value.
// Define PC_SEQ_CALL_STACK_EN to build the CALL/RET return stack; otherwise CALL/RET act as SEQ.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT,
    parameter int STACK_DEPTH = STACK_DEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic            fetch_req,
    input  logic            fetch_ack,
    input  logic [2:0]      flow,
    input  logic            cond,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] next_pc,
    output logic            exec_en,
    output logic [2:0]      state,
    output logic            halted,
    output logic            stack_err
);
    if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_badDepth
        $error("STACK_DEPTH must be a power of two >= 2");
    end

    SeqState stateQ, stateD;
    logic [PC_W-1:0] nextPcQ, nextPcD, targetQ, seqPc;
    logic [2:0] flowQ;
    logic condQ, errQ, errNow;

`ifdef PC_SEQ_CALL_STACK_EN
    logic push, pop, full, empty;
    logic [PC_W-1:0] topData;

    ret_stack #(.PC_W(PC_W), .STACK_DEPTH(STACK_DEPTH)) uStack (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .pushData(seqPc),
        .topData(topData),
        .full(full),
        .empty(empty)
    );
`endif

    assign seqPc = nextPcQ + PC_W'(1);

    // Decoded fields are captured at the end of DECODE and held through EXEC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ <= IDLE;
            nextPcQ <= '0;
            errQ <= 1'b0;
            flowQ <= FLOW_SEQ;
            condQ <= 1'b0;
            targetQ <= '0;
        end else begin
            stateQ <= stateD;
            nextPcQ <= nextPcD;
            errQ <= errQ | errNow;
            if (stateQ == DECODE) begin
                flowQ <= flow;
                condQ <= cond;
                targetQ <= target;
            end
        end
    end

    always_comb begin
        stateD = stateQ;
        nextPcD = nextPcQ;
        errNow = 1'b0;
`ifdef PC_SEQ_CALL_STACK_EN
        push = 1'b0;
        pop = 1'b0;
`endif
        case (stateQ)
            IDLE:   stateD = run ? LOAD : IDLE;
            LOAD:   stateD = FETCH;
            FETCH:  stateD = fetch_ack ? DECODE : FETCH;
            DECODE: stateD = EXEC;
            EXEC: begin
                case (flowQ)
                    FLOW_BR:  nextPcD = condQ ? seqPc + targetQ : seqPc;
                    FLOW_JMP: nextPcD = targetQ;
`ifdef PC_SEQ_CALL_STACK_EN
                    FLOW_CALL: begin
                        errNow = full;
                        push = !full;
                        nextPcD = full ? nextPcQ : targetQ;
                    end
                    FLOW_RET: begin
                        errNow = empty;
                        pop = !empty;
                        nextPcD = empty ? nextPcQ : topData;
                    end
`endif
                    FLOW_HALT: nextPcD = nextPcQ;
                    default:   nextPcD = seqPc;
                endcase
                stateD = (flowQ == FLOW_HALT || errNow) ? HALT : run ? LOAD : IDLE;
            end
            default: stateD = HALT;
        endcase
    end

    assign fetch_req = stateQ == FETCH;
    assign exec_en = stateQ == EXEC;
    assign halted = stateQ == HALT;
    assign state = stateQ;
    assign next_pc = nextPcQ;
    assign stack_err = errQ;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized + directed scoreboard bench against a behavioural next-PC model.
module tb_pc_sequencer;
    localparam int PC_W = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset, run, fetch_ack, cond;
    logic [2:0] flow;
    logic [PC_W-1:0] target, next_pc;
    logic fetch_req, exec_en, halted, stack_err;
    logic [2:0] state;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic err;
        logic halt;
        logic [2:0] st;
        int period;
    } Exp;

    Exp sb[$];
    int checks = 0, errors = 0, cyc = 0;
    logic [PC_W-1:0] mPc;
    logic [PC_W-1:0] mStack[$];
    logic mErr, mHalted, prevLoad;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pc_sequencer #(.PC_W(PC_W), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .run(run),
        .fetch_req(fetch_req),
        .fetch_ack(fetch_ack),
        .flow(flow),
        .cond(cond),
        .target(target),
        .next_pc(next_pc),
        .exec_en(exec_en),
        .state(state),
        .halted(halted),
        .stack_err(stack_err)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: next PC from the instruction rules, stack as a plain queue.
    task automatic model(input logic [2:0] f, input logic c, input logic [PC_W-1:0] t,
                         input logic drop, input int w);
        Exp e;
        logic [PC_W-1:0] seq;
        logic err = 1'b0;
        seq = mPc + 8'd1;
        case (f)
            3'd1: e.pc = c ? seq + t : seq;
            3'd2: e.pc = t;
`ifdef PC_SEQ_CALL_STACK_EN
            3'd3: if (mStack.size() == DEPTH) begin err = 1'b1; e.pc = mPc; end
                  else begin mStack.push_back(seq); e.pc = t; end
            3'd4: if (mStack.size() == 0) begin err = 1'b1; e.pc = mPc; end
                  else e.pc = mStack.pop_back();
`endif
            3'd5: e.pc = mPc;
            default: e.pc = seq;
        endcase
        mErr = mErr | err;
        e.err = mErr;
        e.halt = (f == 3'd5) || err;
        e.st = e.halt ? 3'd5 : drop ? 3'd0 : 3'd1;
        e.period = prevLoad ? 4 + w : 0;
        prevLoad = e.st == 3'd1;
        mPc = e.pc;
        mHalted = e.halt;
        sb.push_back(e);
    endtask

    task automatic doReset();
        @(negedge clk);
        run = 1'b0;
        fetch_ack = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("reset state", state, 0);
        check("reset next_pc", next_pc, 0);
        check("reset fetch_req", fetch_req, 0);
        check("reset exec_en", exec_en, 0);
        check("reset halted", halted, 0);
        check("reset stack_err", stack_err, 0);
        @(negedge clk);
        reset = 1'b0;
        mPc = '0;
        mStack.delete();
        mErr = 1'b0;
        mHalted = 1'b0;
        prevLoad = 1'b0;
        sb.delete();
    endtask

    task automatic doInstr(input logic [2:0] f, input logic c, input logic [PC_W-1:0] t,
                           input int w, input logic drop);
        int n = 0;
        if (mHalted) doReset();
        run = 1'b1;
        while (!fetch_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!fetch_req) begin
            check("fetch_req timeout", 0, 1);
            return;
        end
        for (int i = 0; i < w; i++) begin
            @(negedge clk);
            check("fetch_req held", fetch_req, 1);
        end
        fetch_ack = 1'b1;
        flow = f;
        cond = c;
        target = t;
        model(f, c, t, drop, w);
        @(negedge clk);
        fetch_ack = 1'b0;
        if (drop) run = 1'b0;
        @(negedge clk);
        flow = 3'($urandom);
        cond = 1'($urandom);
        target = 8'($urandom);
        @(negedge clk);
        if (drop) run = 1'b1;
    endtask

    // Monitor: every exec_en strobe retires the oldest expectation.
    initial begin
        Exp e;
        int last;
        last = -1;
        forever begin
            @(negedge clk);
            if (reset) last = -1;
            else if (exec_en) begin
                if (sb.size() == 0) check("unexpected exec_en", 1, 0);
                else begin
                    e = sb.pop_front();
                    if (e.period != 0) check("exec period", cyc - last, e.period);
                    last = cyc;
                    @(negedge clk);
                    check("exec_en one cycle", exec_en, 0);
                    check("next_pc", next_pc, e.pc);
                    check("stack_err", stack_err, e.err);
                    check("halted", halted, e.halt);
                    check("state after exec", state, e.st);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        run = 1'b0;
        fetch_ack = 1'b0;
        flow = 3'd0;
        cond = 1'b0;
        target = '0;
        mHalted = 1'b0;
        doReset();
        repeat (3) doInstr(3'd0, 1'b0, 8'h00, 0, 1'b0);
        doInstr(3'd2, 1'b0, 8'hFF, 0, 1'b0);
        doInstr(3'd0, 1'b0, 8'h00, 0, 1'b0);
        doInstr(3'd2, 1'b0, 8'h10, 0, 1'b0);
        doInstr(3'd1, 1'b1, 8'hFC, 0, 1'b0);
        doInstr(3'd2, 1'b0, 8'h10, 0, 1'b0);
        doInstr(3'd1, 1'b0, 8'hFC, 0, 1'b0);
        doInstr(3'd2, 1'b0, 8'h20, 0, 1'b0);
        doInstr(3'd3, 1'b0, 8'h80, 0, 1'b0);
        doInstr(3'd4, 1'b0, 8'h00, 0, 1'b0);
        for (int i = 0; i < 5; i++) doInstr(3'd3, 1'b0, 8'(8'h40 + 8 * i), 1, 1'b0);
        doInstr(3'd5, 1'b0, 8'h00, 0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            fetch_ack = 1'b1;
        end
        @(negedge clk);
        fetch_ack = 1'b0;
        check("halt absorbing state", state, 5);
        check("halt no fetch", fetch_req, 0);
        check("halt next_pc held", next_pc, mPc);
        doInstr(3'd4, 1'b0, 8'h00, 0, 1'b0);
        repeat (2) @(negedge clk);
        doReset();
        fetch_ack = 1'b1;
        repeat (3) @(negedge clk);
        check("ack ignored in idle", state, 0);
        fetch_ack = 1'b0;
        doInstr(3'd0, 1'b0, 8'h00, 3, 1'b1);
        doInstr(3'd2, 1'b0, 8'h55, 0, 1'b0);
        run = 1'b1;
        n = 0;
        while (!fetch_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("fetch before mid reset", fetch_req, 1);
        doReset();
        for (int i = 0; i < 200; i++)
            doInstr(3'($urandom_range(0, 7)), 1'($urandom), 8'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 7) == 0);
        repeat (4) @(negedge clk);
        check("scoreboard drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch/flow controller for the 8-bit microprocessor core. It sequences instruction fetch and execute, and computes the value driven onto the `pc` module's `NextI` input. That value covers sequential increment, conditional relative branch, absolute jump, call/return via a small return-address stack, and halt. It sits between the instruction decoder and the `pc` register and is the only writer of `NextI`.

## Interface
- `PC_W`, default 8: PC width.
- `STACK_DEPTH`, default 4: number of return-address stack entries (power of two).

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous reset, active-high.
- `run`  in  1  start / continue execution.
- `fetch_req`  out  1  instruction memory read request at the current PC.
- `fetch_ack`  in  1  instruction word is valid this cycle.
- `flow`  in  3  decoded flow op: 0 SEQ, 1 BR, 2 JMP, 3 CALL, 4 RET, 5 HALT, 6–7 treated as SEQ.
- `cond`  in  1  branch condition (ALU flag).
- `target`  in  PC_W  absolute target for JMP/CALL; two's-complement offset for BR.
- `next_pc`  out  PC_W  registered value, drives `pc.NextI`.
- `exec_en`  out  1  one-cycle datapath execute strobe.
- `state`  out  3  current FSM state, for debug.
- `halted`  out  1  core is in HALT.
- `stack_err`  out  1  sticky flag: stack overflow or underflow.

## Operation
- **States:** IDLE=0, LOAD=1, FETCH=2, DECODE=3, EXEC=4, HALT=5.
- **IDLE:** go to LOAD when `run`=1.
- **LOAD:** one settle cycle while `pc` captures `next_pc`; always go to FETCH.
- **FETCH:** `fetch_req`=1 until `fetch_ack`, then go to DECODE.
- **DECODE:** `flow`, `cond` and `target` are sampled at the end of this cycle.
- **EXEC:** `exec_en`=1 for exactly one cycle. `next_pc` updates at the end of EXEC. Next state:
  - HALT if the op is HALT or an error occurred;
  - otherwise LOAD if `run`=1;
  - otherwise IDLE.
- **HALT:** absorbing; exited only by `reset`.
- **next_pc update at the end of EXEC, with P = current `next_pc` (all arithmetic mod 2^PC_W):**
  - SEQ: P+1.
  - BR: P+1+`target` if `cond`=1, else P+1.
  - JMP: `target`.
  - CALL: push P+1, then `target`.
  - RET: pop.
  - HALT: P, unchanged.
- **Overflow:** CALL with the stack full sets `stack_err`, leaves `next_pc` unchanged, and the FSM goes to HALT.
- **Underflow:** RET with the stack empty does the same.
- `run` deasserted mid-instruction: the current instruction completes, then the FSM goes to IDLE.

## Timing
- **Reset values:**
  - `state`=IDLE;
  - `next_pc`=0;
  - `fetch_req`, `exec_en`, `halted`, `stack_err` all 0;
  - stack empty.
- All outputs are registered or decoded from the registered state only; no combinational path from any input to any output.
- Minimum instruction period is 4 cycles (LOAD, FETCH, DECODE, EXEC) with `fetch_ack` in the first FETCH cycle; each extra wait cycle adds 1.
- `fetch_req` may rise no earlier than one cycle after `next_pc` changes, so `pc.NextO` is stable when the request is seen.
- `reset` asserted mid-instruction: the block returns immediately to reset values; an in-flight fetch is abandoned.
- `fetch_ack` outside FETCH is ignored.

## Configuration
- `PC_SEQ_CALL_STACK_EN` defined: the return stack is instantiated and CALL/RET behave as above.
- Not defined:
  - no stack is instantiated;
  - CALL and RET execute as SEQ;
  - `stack_err` is tied to 0.

## Structure
- **Package `pc_seq_pkg`:** flow opcode constants, state encodings, default `PC_W`.
- **Sub-module `ret_stack`:** LIFO of `STACK_DEPTH` x `PC_W` with push/pop and full/empty outputs; instantiated only under the macro.

## Test plan
- Reset, `run`=1, `flow`=SEQ for 3 instructions → `next_pc` goes 0→1→2→3; `exec_en` pulses every 4 cycles.
- `next_pc`=0xFF, SEQ → wraps to 0x00.
- `next_pc`=0x10, BR with `target`=0xFC: `cond`=1 → 0x0D; `cond`=0 → 0x11.
- With the macro: from 0x20, CALL 0x80 → 0x80; then RET → 0x21. Five nested CALLs → `stack_err`=1, `halted`=1, `next_pc` holds.
- RET on an empty stack → `stack_err`=1, HALT. Then `reset` in HALT → IDLE, `next_pc`=0, flags cleared.
- `fetch_ack` delayed 3 cycles while `run` drops during DECODE → instruction completes, FSM goes to IDLE, `fetch_req` stays high throughout the wait.
